// File: rtl/ecc_sram_pkg.sv
// Shared widths, codeword type and SECDED Hamming helpers for the 256x8 ECC SRAM.
// Codeword: bit0 overall parity, bits 12:1 Hamming positions 1..12, bit13 reserved (0).
package ecc_sram_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CW_W   = 14;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  localparam int unsigned HAM_MAX_POS = 12;
  localparam int unsigned POS_OVERALL = 0;
  localparam int unsigned POS_C1      = 1;
  localparam int unsigned POS_C2      = 2;
  localparam int unsigned POS_C4      = 4;
  localparam int unsigned POS_C8      = 8;
  localparam int unsigned POS_RSVD    = 13;

  typedef logic [CW_W-1:0]   codeword_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [3:0]        syndrome_t;

  typedef enum logic [1:0] {
    ERR_CLEAN,
    ERR_SINGLE,
    ERR_DOUBLE
  } err_class_e;

  // Data d0..d7 occupy the non-power-of-two positions 3,5,6,7,9,10,11,12.
  function automatic codeword_t hamming_encode(input data_t d);
    codeword_t cw;
    cw = '0;
    cw[3]  = d[0];
    cw[5]  = d[1];
    cw[6]  = d[2];
    cw[7]  = d[3];
    cw[9]  = d[4];
    cw[10] = d[5];
    cw[11] = d[6];
    cw[12] = d[7];
    cw[POS_C1] = cw[3] ^ cw[5] ^ cw[7] ^ cw[9] ^ cw[11];
    cw[POS_C2] = cw[3] ^ cw[6] ^ cw[7] ^ cw[10] ^ cw[11];
    cw[POS_C4] = cw[5] ^ cw[6] ^ cw[7] ^ cw[12];
    cw[POS_C8] = cw[9] ^ cw[10] ^ cw[11] ^ cw[12];
    cw[POS_OVERALL] = ^cw[HAM_MAX_POS:1];
    return cw;
  endfunction

  function automatic syndrome_t hamming_syndrome(input codeword_t cw);
    syndrome_t s;
    s[0] = cw[1] ^ cw[3] ^ cw[5] ^ cw[7] ^ cw[9]  ^ cw[11];
    s[1] = cw[2] ^ cw[3] ^ cw[6] ^ cw[7] ^ cw[10] ^ cw[11];
    s[2] = cw[4] ^ cw[5] ^ cw[6] ^ cw[7] ^ cw[12];
    s[3] = cw[8] ^ cw[9] ^ cw[10] ^ cw[11] ^ cw[12];
    return s;
  endfunction

  function automatic logic overall_parity(input codeword_t cw);
    return ^cw[HAM_MAX_POS:0];
  endfunction

  function automatic data_t extract_data(input codeword_t cw);
    return {cw[12], cw[11], cw[10], cw[9], cw[7], cw[6], cw[5], cw[3]};
  endfunction

  // Odd parity with an in-range syndrome is a single flip (s=0 means bit0 itself);
  // anything else that is not clean is treated as uncorrectable.
  function automatic err_class_e classify(input syndrome_t s, input logic p);
    err_class_e c;
    if (!p && (s == '0))
      c = ERR_CLEAN;
    else if (p && (32'(s) <= HAM_MAX_POS))
      c = ERR_SINGLE;
    else
      c = ERR_DOUBLE;
    return c;
  endfunction

endpackage

// File: rtl/secded_decoder.sv
// Combinational SECDED decoder: classifies a stored codeword and returns corrected data/codeword.
module secded_decoder
  import ecc_sram_pkg::*;
(
  input  logic [CW_W-1:0]   i_cw,
  output logic [DATA_W-1:0] o_data,
  output logic [CW_W-1:0]   o_cw,
  output logic              o_sec,
  output logic              o_ded
);

  syndrome_t  w_syn;
  logic       w_par;
  err_class_e w_class;
  codeword_t  w_flip;

  always_comb begin
    w_syn   = hamming_syndrome(i_cw);
    w_par   = overall_parity(i_cw);
    w_class = classify(w_syn, w_par);
    w_flip  = '0;
    if (w_class == ERR_SINGLE)
      w_flip[w_syn] = 1'b1;
  end

  // Double errors leave w_flip clear, so the data taken from o_cw is the raw data.
  always_comb begin
    o_cw           = i_cw ^ w_flip;
    o_cw[POS_RSVD] = 1'b0;
    o_data         = extract_data(o_cw);
    o_sec          = (w_class == ERR_SINGLE);
    o_ded          = (w_class == ERR_DOUBLE);
  end

endmodule

// File: rtl/ecc_sram_top.sv
// Single-port 256x8 SRAM wrapper with SECDED Hamming protection and registered read port.
// Define ECC_SCRUB_WRITEBACK_EN to write corrected words back on single-error reads.
module ecc_sram_top
  import ecc_sram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              sec_err,
  output logic              ded_err
);

  codeword_t mem [DEPTH];

  logic        w_wr;
  logic        w_rd;
  codeword_t   w_rd_cw;
  logic [DATA_W-1:0] w_dec_data;
  codeword_t   w_dec_cw;
  logic        w_dec_sec;
  logic        w_dec_ded;

  logic [DATA_W-1:0] r_data_out;
  logic              r_sec_err;
  logic              r_ded_err;

  assign w_wr    = enable && we;
  assign w_rd    = enable && !we;
  assign w_rd_cw = mem[addr];

  secded_decoder u_dec (
    .i_cw   (w_rd_cw),
    .o_data (w_dec_data),
    .o_cw   (w_dec_cw),
    .o_sec  (w_dec_sec),
    .o_ded  (w_dec_ded)
  );

  // Array is not reset; a write coinciding with rst still lands.
`ifdef ECC_SCRUB_WRITEBACK_EN
  always_ff @(posedge clk) begin
    if (w_wr)
      mem[addr] <= hamming_encode(data_in);
    else if (w_rd && w_dec_sec)
      mem[addr] <= w_dec_cw;
  end
`else
  logic w_unused_dec_cw;
  assign w_unused_dec_cw = ^w_dec_cw;

  always_ff @(posedge clk) begin
    if (w_wr)
      mem[addr] <= hamming_encode(data_in);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out <= '0;
      r_sec_err  <= 1'b0;
      r_ded_err  <= 1'b0;
    end else if (w_rd) begin
      r_data_out <= w_dec_data;
      r_sec_err  <= w_dec_sec;
      r_ded_err  <= w_dec_ded;
    end
  end

  assign data_out = r_data_out;
  assign sec_err  = r_sec_err;
  assign ded_err  = r_ded_err;

endmodule

// File: tb/tb_ecc_sram_top.sv
// Self-checking bench for ecc_sram_top: directed scenarios plus randomized traffic with error injection.
module tb_ecc_sram_top;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       we;
  logic [7:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       sec_err;
  logic       ded_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [13:0] model_cw [256];
  logic [7:0]  exp_d = 8'h00;
  logic        exp_s = 1'b0;
  logic        exp_e = 1'b0;

  ecc_sram_top dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .sec_err  (sec_err),
    .ded_err  (ded_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference encoder: place data, then pick check bits so the XOR of set positions is zero.
  function automatic logic [13:0] ref_encode(input logic [7:0] d);
    int          dpos [8] = '{3, 5, 6, 7, 9, 10, 11, 12};
    logic [13:0] cw = '0;
    int          s  = 0;
    for (int i = 0; i < 8; i++)
      if (d[i]) begin
        cw[dpos[i]] = 1'b1;
        s = s ^ dpos[i];
      end
    for (int k = 0; k < 4; k++)
      if (s[k]) cw[1 << k] = 1'b1;
    cw[0] = ^cw[12:1];
    return cw;
  endfunction

  function automatic logic [7:0] ref_data(input logic [13:0] cw);
    int         dpos [8] = '{3, 5, 6, 7, 9, 10, 11, 12};
    logic [7:0] d = '0;
    for (int i = 0; i < 8; i++) d[i] = cw[dpos[i]];
    return d;
  endfunction

  task automatic ref_decode(input logic [13:0] cw, output logic [7:0] d, output logic sec,
                            output logic ded, output logic [13:0] fx);
    int   s = 0;
    logic p;
    for (int pos = 1; pos <= 12; pos++)
      if (cw[pos]) s = s ^ pos;
    p   = ^cw[12:0];
    fx  = cw;
    sec = 1'b0;
    ded = 1'b0;
    if (p && s <= 12) begin
      sec    = 1'b1;
      fx[s]  = ~fx[s];
      fx[13] = 1'b0;
    end else if (p || s != 0) begin
      ded = 1'b1;
    end
    d = ref_data(fx);
  endtask

  // One clock of traffic; the model advances alongside and outputs are checked 1ns after the edge.
  task automatic step(input logic r, input logic en, input logic w, input logic [7:0] a,
                      input logic [7:0] d);
    logic [7:0]  rd = '0;
    logic        rs = 1'b0;
    logic        re = 1'b0;
    logic [13:0] fx = '0;
    rst = r; enable = en; we = w; addr = a; data_in = d;
    if (en && !w) ref_decode(model_cw[a], rd, rs, re, fx);
    @(posedge clk);
    #1;
    if (en && w) begin
      model_cw[a] = ref_encode(d);
    end else if (en) begin
`ifdef ECC_SCRUB_WRITEBACK_EN
      if (rs) model_cw[a] = fx;
`endif
      if (!r) begin
        exp_d = rd; exp_s = rs; exp_e = re;
      end
    end
    if (r) begin
      exp_d = 8'h00; exp_s = 1'b0; exp_e = 1'b0;
    end
    check_eq("data_out", 32'(data_out), 32'(exp_d));
    check_eq("sec_err",  32'(sec_err),  32'(exp_s));
    check_eq("ded_err",  32'(ded_err),  32'(exp_e));
  endtask

  task automatic flip(input logic [7:0] a, input logic [13:0] mask);
    dut.mem[a]  = dut.mem[a] ^ mask;
    model_cw[a] = model_cw[a] ^ mask;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; we = 1'b0; addr = '0; data_in = '0;

    step(1'b1, 1'b0, 1'b0, 8'd0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'd0, 8'h00);
    check_eq("reset_dout", 32'(data_out), 32'h00);

    step(1'b0, 1'b0, 1'b0, 8'd42, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'd42, 8'h00);
    check_eq("idle_dout", 32'(data_out), 32'h00);
    check_eq("idle_flags", 32'({sec_err, ded_err}), 32'h0);

    step(1'b0, 1'b1, 1'b1, 8'd10,  8'h2C);
    step(1'b0, 1'b1, 1'b1, 8'd20,  8'h3C);
    step(1'b0, 1'b1, 1'b1, 8'd255, 8'hFF);
    check_eq("enc_2C_literal", 32'(dut.mem[10]), 32'h05C6);
    check_eq("enc_FF", 32'(dut.mem[255]), 32'(ref_encode(8'hFF)));
    step(1'b0, 1'b1, 1'b0, 8'd10,  8'h00);
    check_eq("rd10", 32'(data_out), 32'h2C);
    step(1'b0, 1'b1, 1'b0, 8'd20,  8'h00);
    check_eq("rd20", 32'(data_out), 32'h3C);
    step(1'b0, 1'b1, 1'b0, 8'd255, 8'h00);
    check_eq("rd255", 32'(data_out), 32'hFF);

    flip(8'd20, 14'h0004);
    step(1'b0, 1'b1, 1'b0, 8'd20, 8'h00);
    check_eq("sec_rd20", 32'(data_out), 32'h3C);
    check_eq("sec_flag20", 32'({sec_err, ded_err}), 32'h2);
    check_eq("mem20_after", 32'(dut.mem[20]), 32'(model_cw[20]));

    step(1'b0, 1'b1, 1'b1, 8'd40, 8'h4C);
    flip(8'd40, 14'h0808);
    step(1'b0, 1'b1, 1'b0, 8'd40, 8'h00);
    check_eq("ded_raw40", 32'(data_out), 32'h0D);
    check_eq("ded_flag40", 32'({sec_err, ded_err}), 32'h1);
    check_eq("mem40_unchanged", 32'(dut.mem[40]), 32'(model_cw[40]));

    step(1'b0, 1'b1, 1'b1, 8'd30, 8'hA8);
    step(1'b0, 1'b1, 1'b1, 8'd40, 8'h4C);
    step(1'b0, 1'b1, 1'b1, 8'd50, 8'h2F);
    step(1'b0, 1'b1, 1'b0, 8'd40, 8'h00);
    check_eq("seq40", 32'(data_out), 32'h4C);
    step(1'b0, 1'b0, 1'b0, 8'd50, 8'h00);
    check_eq("seq_hold", 32'(data_out), 32'h4C);
    step(1'b0, 1'b1, 1'b0, 8'd50, 8'h00);
    check_eq("seq50", 32'(data_out), 32'h2F);
    step(1'b0, 1'b1, 1'b0, 8'd30, 8'h00);
    check_eq("seq30", 32'(data_out), 32'hA8);

    flip(8'd50, 14'h0001);
    step(1'b0, 1'b1, 1'b0, 8'd50, 8'h00);
    check_eq("p0_rd50", 32'(data_out), 32'h2F);
    check_eq("p0_flag50", 32'({sec_err, ded_err}), 32'h2);

    step(1'b0, 1'b1, 1'b1, 8'd70, 8'h11);
    check_eq("wr_hold", 32'({data_out, sec_err}), 32'({8'h2F, 1'b1}));

    step(1'b1, 1'b1, 1'b1, 8'd60, 8'h55);
    check_eq("rst_wr_mem", 32'(dut.mem[60]), 32'(ref_encode(8'h55)));
    step(1'b1, 1'b1, 1'b0, 8'd60, 8'h00);
    check_eq("rst_rd_dout", 32'(data_out), 32'h00);
    step(1'b0, 1'b1, 1'b0, 8'd60, 8'h00);
    check_eq("rd60", 32'(data_out), 32'h55);

    for (int unsigned a = 0; a < 16; a++)
      step(1'b0, 1'b1, 1'b1, 8'(a), 8'($urandom));

    for (int unsigned it = 0; it < 400; it++) begin
      int unsigned r;
      logic [7:0]  ra;
      int unsigned b1;
      int unsigned b2;
      logic [13:0] m;
      r  = $urandom_range(0, 9);
      ra = 8'($urandom_range(0, 15));
      if (r < 3) begin
        step(1'b0, 1'b1, 1'b1, ra, 8'($urandom));
      end else if (r < 8) begin
        step(1'b0, 1'b1, 1'b0, ra, 8'($urandom));
      end else if (r == 8) begin
        step(1'b0, 1'b0, 1'($urandom_range(0, 1)), ra, 8'($urandom));
      end else begin
        b1 = $urandom_range(0, 13);
        m  = '0;
        m[b1] = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
          b2 = (b1 + $urandom_range(1, 13)) % 14;
          m[b2] = 1'b1;
        end
        flip(ra, m);
      end
    end

    for (int unsigned a = 0; a < 16; a++)
      check_eq("rand_mem", 32'(dut.mem[a]), 32'(model_cw[a]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
